// File: rtl/axi_lite_to_apb_dw.sv
// AXI4-Lite to narrow APB4 bridge: each access is split into AxiDataWidth/ApbDataWidth APB beats.
// Optional per-beat ACCESS timeout is built when AXI_LITE_TO_APB_DW_TIMEOUT_EN is defined.
package axi_lite_to_apb_dw_pkg;
    localparam int unsigned AW     = 32;
    localparam int unsigned AXI_DW = 32;
    localparam int unsigned APB_DW = 8;

    typedef struct packed {
        logic [AW-1:0]       aw_addr;
        logic [2:0]          aw_prot;
        logic                aw_valid;
        logic [AXI_DW-1:0]   w_data;
        logic [AXI_DW/8-1:0] w_strb;
        logic                w_valid;
        logic                b_ready;
        logic [AW-1:0]       ar_addr;
        logic [2:0]          ar_prot;
        logic                ar_valid;
        logic                r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic              aw_ready;
        logic              w_ready;
        logic              b_valid;
        logic [1:0]        b_resp;
        logic              ar_ready;
        logic              r_valid;
        logic [AXI_DW-1:0] r_data;
        logic [1:0]        r_resp;
    } axi_lite_resp_t;

    typedef struct packed {
        logic [AW-1:0]       paddr;
        logic [2:0]          pprot;
        logic                psel;
        logic                penable;
        logic                pwrite;
        logic [APB_DW-1:0]   pwdata;
        logic [APB_DW/8-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic              pready;
        logic [APB_DW-1:0] prdata;
        logic              pslverr;
    } apb_resp_t;

    typedef struct packed {
        logic [31:0]   idx;
        logic [AW-1:0] start_addr;
        logic [AW-1:0] end_addr;
    } rule_t;
endpackage

module axi_lite_to_apb_dw #(
    parameter int unsigned NoApbSlaves   = 8,
    parameter int unsigned NoRules       = 9,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned AxiDataWidth  = 32,
    parameter int unsigned ApbDataWidth  = 8,
    parameter int unsigned TimeoutCycles = 16,
    parameter type axi_lite_req_t  = axi_lite_to_apb_dw_pkg::axi_lite_req_t,
    parameter type axi_lite_resp_t = axi_lite_to_apb_dw_pkg::axi_lite_resp_t,
    parameter type apb_req_t       = axi_lite_to_apb_dw_pkg::apb_req_t,
    parameter type apb_resp_t      = axi_lite_to_apb_dw_pkg::apb_resp_t,
    parameter type rule_t          = axi_lite_to_apb_dw_pkg::rule_t
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  axi_lite_req_t                    axi_lite_req_i,
    output axi_lite_resp_t                   axi_lite_resp_o,
    output apb_req_t  [NoApbSlaves-1:0]      apb_req_o,
    input  apb_resp_t [NoApbSlaves-1:0]      apb_resp_i,
    input  rule_t     [NoRules-1:0]          addr_map_i
);
    localparam int unsigned Ratio    = AxiDataWidth / ApbDataWidth;
    localparam int unsigned BeatW    = $clog2(Ratio);
    localparam int unsigned AxiStrbW = AxiDataWidth / 8;
    localparam int unsigned ApbStrbW = ApbDataWidth / 8;
    localparam int unsigned AlignLsb = $clog2(AxiStrbW);
    localparam int unsigned SelW     = (NoApbSlaves > 1) ? $clog2(NoApbSlaves) : 1;

    if (ApbDataWidth >= AxiDataWidth || ApbDataWidth < 8 || AxiDataWidth < 16 || TimeoutCycles == 0)
    begin : g_bad_cfg
        $error("axi_lite_to_apb_dw: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
    state_e state_q, state_d;

    logic [AddrWidth-1:0]    addr_q;
    logic [AxiDataWidth-1:0] wdata_q, rdata_q;
    logic [AxiStrbW-1:0]     strb_q;
    logic [2:0]              prot_q;
    logic [SelW-1:0]         sel_q;
    logic [BeatW-1:0]        beat_q;
    logic                    write_q, prio_wr_q, err_q, decerr_q;

    logic                 wr_elig, sel_rd, sel_wr, accept, dec_hit, timeout;
    logic [AddrWidth-1:0] req_addr, paddr;
    logic [SelW-1:0]      dec_idx;
    logic [BeatW-1:0]     first_beat, next_beat;
    logic                 first_any, next_any;
    apb_resp_t            cur_rsp;

    assign cur_rsp = apb_resp_i[sel_q];

    // Read wins a conflict unless it was the type served last.
    always_comb begin
        wr_elig  = axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid;
        sel_rd   = axi_lite_req_i.ar_valid && (!wr_elig || !prio_wr_q);
        sel_wr   = wr_elig && !sel_rd;
        accept   = (state_q == IDLE) && (sel_rd || sel_wr);
        req_addr = sel_wr ? axi_lite_req_i.aw_addr : axi_lite_req_i.ar_addr;
    end

    // Lowest-numbered matching rule wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NoRules - 1; i >= 0; i--) begin
            if (req_addr >= addr_map_i[i].start_addr && req_addr < addr_map_i[i].end_addr &&
                addr_map_i[i].idx < NoApbSlaves) begin
                dec_hit = 1'b1;
                dec_idx = SelW'(addr_map_i[i].idx);
            end
        end
    end

    // Reads use every beat; writes skip beats whose strobe slice is empty.
    always_comb begin
        first_any  = 1'b0;
        first_beat = '0;
        next_any   = 1'b0;
        next_beat  = '0;
        for (int k = Ratio - 1; k >= 0; k--) begin
            if (!sel_wr || (|axi_lite_req_i.w_strb[k*ApbStrbW +: ApbStrbW])) begin
                first_any  = 1'b1;
                first_beat = BeatW'(k);
            end
            if (k > int'(beat_q) && (!write_q || (|strb_q[k*ApbStrbW +: ApbStrbW]))) begin
                next_any  = 1'b1;
                next_beat = BeatW'(k);
            end
        end
    end

`ifdef AXI_LITE_TO_APB_DW_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    assign timeout = (state_q == ACCESS) && !cur_rsp.pready && (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 cnt_q <= '0;
        else if (state_q != ACCESS)  cnt_q <= '0;
        else                         cnt_q <= cnt_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (dec_hit && first_any) ? SETUP : RESP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (cur_rsp.pready) state_d = next_any ? SETUP : RESP;
                else if (timeout)   state_d = RESP;
            end
            RESP:    if (write_q ? axi_lite_req_i.b_ready : axi_lite_req_i.r_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            sel_q     <= '0;
            beat_q    <= '0;
            write_q   <= 1'b0;
            prio_wr_q <= 1'b0;
            err_q     <= 1'b0;
            decerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q   <= sel_wr;
                prio_wr_q <= sel_rd;
                addr_q    <= req_addr;
                wdata_q   <= sel_wr ? axi_lite_req_i.w_data : '0;
                strb_q    <= sel_wr ? axi_lite_req_i.w_strb : '0;
                prot_q    <= sel_wr ? axi_lite_req_i.aw_prot : axi_lite_req_i.ar_prot;
                sel_q     <= dec_idx;
                beat_q    <= first_beat;
                rdata_q   <= '0;
                err_q     <= 1'b0;
                decerr_q  <= !dec_hit;
            end else if (state_q == ACCESS) begin
                if (cur_rsp.pready) begin
                    if (!write_q) rdata_q[int'(beat_q)*ApbDataWidth +: ApbDataWidth] <= cur_rsp.prdata;
                    err_q <= err_q | cur_rsp.pslverr;
                    if (next_any) beat_q <= next_beat;
                end else if (timeout) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign paddr = {addr_q[AddrWidth-1:AlignLsb], {AlignLsb{1'b0}}} + (AddrWidth'(beat_q) << $clog2(ApbStrbW));

    always_comb begin
        axi_lite_resp_o          = '0;
        axi_lite_resp_o.aw_ready = accept && sel_wr;
        axi_lite_resp_o.w_ready  = accept && sel_wr;
        axi_lite_resp_o.ar_ready = accept && sel_rd;
        axi_lite_resp_o.b_valid  = (state_q == RESP) && write_q;
        axi_lite_resp_o.r_valid  = (state_q == RESP) && !write_q;
        axi_lite_resp_o.b_resp   = decerr_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);
        axi_lite_resp_o.r_resp   = axi_lite_resp_o.b_resp;
        axi_lite_resp_o.r_data   = rdata_q;
    end

    always_comb begin
        apb_req_o = '0;
        for (int unsigned i = 0; i < NoApbSlaves; i++) begin
            apb_req_o[i].paddr   = paddr;
            apb_req_o[i].pprot   = prot_q;
            apb_req_o[i].pwrite  = write_q;
            apb_req_o[i].pwdata  = wdata_q[int'(beat_q)*ApbDataWidth +: ApbDataWidth];
            apb_req_o[i].pstrb   = strb_q[int'(beat_q)*ApbStrbW +: ApbStrbW];
            apb_req_o[i].psel    = (state_q == SETUP || state_q == ACCESS) && (sel_q == SelW'(i));
            apb_req_o[i].penable = (state_q == ACCESS) && (sel_q == SelW'(i));
        end
    end
endmodule

// File: tb/tb_axi_lite_to_apb_dw.sv
// Bench for axi_lite_to_apb_dw: vector table, hand sequences and random traffic vs a beat-level model.
module tb_axi_lite_to_apb_dw;
    import axi_lite_to_apb_dw_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    axi_lite_req_t    req = '0;
    axi_lite_resp_t   rsp;
    apb_req_t  [7:0]  apb_req;
    apb_resp_t [7:0]  apb_rsp = '0;
    rule_t     [8:0]  map;

    axi_lite_to_apb_dw dut (
        .clk_i(clk), .rst_ni(rst_n), .axi_lite_req_i(req), .axi_lite_resp_o(rsp),
        .apb_req_o(apb_req), .apb_resp_i(apb_rsp), .addr_map_i(map)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] slv; logic [31:0] paddr; logic pwrite; logic [7:0] pwdata; logic pstrb; logic [2:0] pprot;
    } beat_t;

    typedef struct {
        bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
        logic [1:0] exp_resp; logic [31:0] exp_rdata; int exp_nb; int exp_lat;
    } vec_t;

    int n_cmp = 0, n_fail = 0, mon_err = 0;
    beat_t got_q[$], exp_q[$];
    logic [7:0] mem [logic [31:0]];
    bit hang = 0;
    int wait_cfg = 0, wcnt = 0, pen_run = 0, pen_max = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [7:0] psel_v, pen_v;
    logic [1:0] m_resp;
    logic [31:0] m_rdata;
    int m_lat;

    always_comb for (int i = 0; i < 8; i++) begin psel_v[i] = apb_req[i].psel; pen_v[i] = apb_req[i].penable; end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
    endfunction

    // APB completer model: wait states, error address, optional hang; logs every completed beat.
    logic [31:0] s_paddr; logic s_pwrite; logic [7:0] s_pwdata; logic s_pstrb; bit prev_setup = 0;
    always @(negedge clk) begin
        int nsel, s;
        apb_rsp = '0;
        nsel = 0; s = 0;
        for (int i = 0; i < 8; i++) if (psel_v[i]) begin nsel++; s = i; end
        if (rst_n) begin
            if (nsel > 1 || (pen_v & ~psel_v) != 0) mon_err++;
            if (nsel == 1 && pen_v[s]) begin
                pen_run++;
                if (pen_run > pen_max) pen_max = pen_run;
                if (pen_run == 1 && !prev_setup) mon_err++;
                if (apb_req[s].paddr !== s_paddr || apb_req[s].pwrite !== s_pwrite ||
                    apb_req[s].pwdata !== s_pwdata || apb_req[s].pstrb !== s_pstrb) mon_err++;
                if (!hang && wcnt >= wait_cfg) begin
                    apb_rsp[s].pready  = 1'b1;
                    apb_rsp[s].prdata  = rd_byte(apb_req[s].paddr);
                    apb_rsp[s].pslverr = (apb_req[s].paddr == err_addr);
                    if (apb_req[s].pwrite && apb_req[s].pstrb[0]) mem[apb_req[s].paddr] = apb_req[s].pwdata;
                    got_q.push_back({3'(s), apb_req[s].paddr, apb_req[s].pwrite, apb_req[s].pwdata,
                                     apb_req[s].pstrb, apb_req[s].pprot});
                end else wcnt++;
            end else begin
                wcnt = 0; pen_run = 0;
                if (nsel == 1) begin
                    s_paddr = apb_req[s].paddr; s_pwrite = apb_req[s].pwrite;
                    s_pwdata = apb_req[s].pwdata; s_pstrb = apb_req[s].pstrb;
                end
            end
        end
        prev_setup = (nsel == 1) && !pen_v[s];
    end

    // Reference: decode, list the beats the access must produce, predict response, data and latency.
    function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, input logic [2:0] prot);
        bit hit = 0; int slv = 0; logic [31:0] base;
        exp_q.delete();
        for (int i = 0; i < 9; i++)
            if (!hit && addr >= map[i].start_addr && addr < map[i].end_addr) begin hit = 1; slv = map[i].idx; end
        base = {addr[31:2], 2'b00};
        m_rdata = '0; m_resp = 2'b00; m_lat = 1;
        if (!hit) begin m_resp = 2'b11; return; end
        for (int k = 0; k < 4; k++) begin
            if (!wr || strb[k]) begin
                exp_q.push_back({3'(slv), base + 32'(k), wr, wr ? data[8*k +: 8] : 8'h00, wr, prot});
                if (base + 32'(k) == err_addr) m_resp = 2'b10;
                if (!wr) m_rdata[8*k +: 8] = rd_byte(base + 32'(k));
                m_lat += 2 + wait_cfg;
            end
        end
    endfunction

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, input int rdy_dly,
                           output logic [1:0] resp, output logic [31:0] rdata, output int lat);
        int n = 0;
        got_q.delete();
        @(negedge clk);
        if (wr) begin
            req.aw_addr = addr; req.aw_prot = prot; req.aw_valid = 1; req.w_data = data; req.w_strb = strb; req.w_valid = 1;
        end else begin
            req.ar_addr = addr; req.ar_prot = prot; req.ar_valid = 1;
        end
        #1;
        while (!(wr ? (rsp.aw_ready && rsp.w_ready) : rsp.ar_ready) && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin n_fail++; $display("FAIL accept_timeout: no ready within 100 cycles"); end
        @(posedge clk); #1;
        req.aw_valid = 0; req.w_valid = 0; req.ar_valid = 0;
        lat = 1;
        while (!(wr ? rsp.b_valid : rsp.r_valid) && lat < 200) begin @(posedge clk); #1; lat++; end
        if (lat >= 200) begin n_fail++; $display("FAIL resp_timeout: no valid within 200 cycles"); end
        resp  = wr ? rsp.b_resp : rsp.r_resp;
        rdata = rsp.r_data;
        repeat (rdy_dly) begin @(posedge clk); #1; end
        chk("valid_hold", wr ? rsp.b_valid : rsp.r_valid, 1);
        req.b_ready = wr; req.r_ready = !wr;
        @(posedge clk); #1;
        req.b_ready = 0; req.r_ready = 0;
        chk("valid_drop", {rsp.b_valid, rsp.r_valid}, 0);
    endtask

    task automatic checked_txn(input string tag, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [2:0] prot, input int rdy_dly,
                               output logic [1:0] resp, output logic [31:0] rdata, output int lat);
        model(wr, addr, data, strb, prot);
        run_txn(wr, addr, data, strb, prot, rdy_dly, resp, rdata, lat);
        chk({tag, "_resp"}, resp, m_resp);
        if (!wr) chk({tag, "_rdata"}, rdata, m_rdata);
        chk({tag, "_latency"}, lat, m_lat);
        chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk({tag, "_beat"}, got_q[i], exp_q[i]);
    endtask

    vec_t tbl [10];
    logic [1:0] resp; logic [31:0] rdata, addr; int lat, n; bit wr, served;

    initial begin
        for (int i = 0; i < 8; i++) map[i] = '{32'(i), 32'h2000 + 32'(i) * 32'h1000, 32'h3000 + 32'(i) * 32'h1000};
        map[8] = '{32'd2, 32'h0000_A000, 32'h0000_C000};
        mem[32'h3004] = 8'h11; mem[32'h3005] = 8'h22; mem[32'h3006] = 8'h33; mem[32'h3007] = 8'h44;

        tbl[0] = '{0, 32'h0000_3004, 32'h0,         4'h0, 2'b00, 32'h4433_2211, 4, 9};
        tbl[1] = '{1, 32'h0000_8000, 32'hA5A5_0000, 4'hC, 2'b00, 32'h0,         2, 5};
        tbl[2] = '{1, 32'h0000_8000, 32'h1234_5678, 4'h0, 2'b00, 32'h0,         0, 1};
        tbl[3] = '{0, 32'h0003_0000, 32'h0,         4'h0, 2'b11, 32'h0,         0, 1};
        tbl[4] = '{1, 32'h0000_5008, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         4, 9};
        tbl[5] = '{0, 32'h0000_5008, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 4, 9};
        tbl[6] = '{1, 32'h0000_B000, 32'h0000_00EE, 4'h1, 2'b00, 32'h0,         1, 3};
        tbl[7] = '{0, 32'h0000_B002, 32'h0,         4'h0, 2'b00, 32'h5958_5BEE, 4, 9};
        tbl[8] = '{1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 2'b11, 32'h0,         0, 1};
        tbl[9] = '{1, 32'h0000_2000, 32'hAA00_00BB, 4'h9, 2'b00, 32'h0,         2, 5};

        repeat (3) @(posedge clk); #1;
        chk("rst_psel", psel_v, 0);
        chk("rst_penable", pen_v, 0);
        chk("rst_readies", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, 0);
        chk("rst_valids", {rsp.b_valid, rsp.r_valid}, 0);
        chk("rst_apb_bus", {apb_req[0].paddr, apb_req[0].pwdata, apb_req[0].pstrb}, 0);
        chk("rst_rdata", rsp.r_data, 0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            checked_txn("tbl", tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, 3'd2, i % 3, resp, rdata, lat);
            chk("tbl_const_resp", resp, tbl[i].exp_resp);
            if (!tbl[i].wr) chk("tbl_const_rdata", rdata, tbl[i].exp_rdata);
            chk("tbl_const_nbeats", got_q.size(), tbl[i].exp_nb);
            chk("tbl_const_latency", lat, tbl[i].exp_lat);
        end

        // Slave error on beat 1 of 4: every beat still issued, SLVERR returned.
        err_addr = 32'h0000_3005;
        checked_txn("pslverr", 0, 32'h0000_3004, 0, 0, 3'd0, 0, resp, rdata, lat);
        chk("pslverr_resp", resp, 2'b10);
        chk("pslverr_nbeats", got_q.size(), 4);
        err_addr = 32'hFFFF_FFFF;

        // Reset in the middle of an ACCESS phase drops the transaction.
        hang = 1;
        @(negedge clk); req.ar_addr = 32'h0000_3004; req.ar_valid = 1;
        @(posedge clk); #1; req.ar_valid = 0;
        repeat (4) @(posedge clk); #1;
        chk("hang_in_access", pen_v, 8'h02);
        rst_n = 0; #1;
        chk("midrst_psel", psel_v, 0);
        chk("midrst_penable", pen_v, 0);
        chk("midrst_valids", {rsp.b_valid, rsp.r_valid}, 0);
        @(negedge clk); rst_n = 1; hang = 0;
        repeat (3) @(posedge clk); #1;
        chk("midrst_no_resp", {rsp.b_valid, rsp.r_valid}, 0);

        // Simultaneous read and write requests alternate, read first after reset.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req.ar_addr = 32'h0003_0000; req.ar_valid = 1;
            req.aw_addr = 32'h0000_8000; req.aw_valid = 1; req.w_data = 0; req.w_strb = 0; req.w_valid = 1;
            #1; n = 0;
            while (!(rsp.ar_ready || rsp.aw_ready) && n < 50) begin @(negedge clk); #1; n++; end
            served = rsp.aw_ready;
            chk("arb_order", served, 64'(i % 2));
            chk("arb_single_grant", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, served ? 3'b110 : 3'b001);
            @(posedge clk); #1;
            req.ar_valid = 0; req.aw_valid = 0; req.w_valid = 0;
            n = 0;
            while (!(served ? rsp.b_valid : rsp.r_valid) && n < 50) begin @(posedge clk); #1; n++; end
            chk("arb_resp", served ? rsp.b_resp : rsp.r_resp, served ? 2'b00 : 2'b11);
            req.b_ready = served; req.r_ready = !served;
            @(posedge clk); #1; req.b_ready = 0; req.r_ready = 0;
        end

`ifdef AXI_LITE_TO_APB_DW_TIMEOUT_EN
        hang = 1; pen_max = 0;
        run_txn(0, 32'h0000_3004, 0, 0, 3'd0, 0, resp, rdata, lat);
        chk("tmo_resp", resp, 2'b10);
        chk("tmo_access_cycles", pen_max, 16);
        chk("tmo_latency", lat, 18);
        chk("tmo_nbeats", got_q.size(), 0);
        hang = 0;
        checked_txn("after_tmo", 0, 32'h0000_3004, 0, 0, 3'd1, 0, resp, rdata, lat);
        wait_cfg = 15;
        checked_txn("pready_at_expiry", 0, 32'h0000_5008, 0, 0, 3'd0, 0, resp, rdata, lat);
        wait_cfg = 0;
`endif

        for (int t = 0; t < 60; t++) begin
            wr = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 9);
            if (n < 8) addr = 32'h2000 + $urandom_range(0, 32'h9FFF);
            else addr = (n == 8) ? 32'h1000 + $urandom_range(0, 32'hFFF) : 32'h0003_0000 + $urandom_range(0, 32'hFFFF);
            wait_cfg = $urandom_range(0, 3);
            err_addr = ($urandom_range(0, 3) == 0) ? {addr[31:2], 2'b00} + $urandom_range(0, 3) : 32'hFFFF_FFFF;
            checked_txn("rand", wr, addr, $urandom, ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                        3'($urandom_range(0, 7)), $urandom_range(0, 2), resp, rdata, lat);
        end

        chk("apb_protocol_monitor", mon_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_to_apb_dw.md
# axi_lite_to_apb_dw

Bridge from one AXI4-Lite slave port to `NoApbSlaves` APB4 completers whose data bus is narrower than the AXI-Lite bus. Each AXI-Lite access is serialised into `AxiDataWidth/ApbDataWidth` APB beats, and write beats with an all-zero strobe slice are skipped. The block decodes addresses against a rule map, arbitrates fairly between reads and writes, and merges the per-beat errors into one AXI response. It sits between the peripheral AXI-Lite crossbar and narrow (8/16-bit) legacy APB peripherals.

## Interface
Parameters:
- `NoApbSlaves`, 8: number of APB completers; one `psel` per completer.
- `NoRules`, 9: number of address rules; several rules may map to the same completer.
- `AddrWidth`, 32: AXI and APB address width.
- `AxiDataWidth`, 32: AXI-Lite data width; must be a power of two and at least 16.
- `ApbDataWidth`, 8: APB data width; a power of two, at least 8, and strictly less than `AxiDataWidth`.
- `TimeoutCycles`, 16: ACCESS-phase cycle limit per beat. Used only when the timeout macro is defined.
- `axi_lite_req_t`, `axi_lite_resp_t`, `apb_req_t`, `apb_resp_t`, `rule_t`: channel and rule struct types. APB structs use `ApbDataWidth` data.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `axi_lite_req_i` in struct: AW/W/AR channels, `b_ready`, `r_ready`.
- `axi_lite_resp_o` out struct: channel readies, B and R channels.
- `apb_req_o` out `[NoApbSlaves]` apb_req_t: APB requests. `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot` are shared across completers; `psel` is one-hot.
- `apb_resp_i` in `[NoApbSlaves]` apb_resp_t: `pready`, `prdata`, `pslverr`.
- `addr_map_i` in `[NoRules]` rule_t: address map; `end_addr` is exclusive.

## Operation
- Ratio R = AxiDataWidth/ApbDataWidth; beat byte width BB = ApbDataWidth/8. Beat k (k = 0..R-1) uses paddr = {addr[AW-1:log2(AxiDataWidth/8)], 0} + k*BB.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE → request selection.** A write is eligible when `aw_valid` and `w_valid` are both high; a read is eligible when `ar_valid` is high. If both are eligible, the type that was not served last wins. The first conflict after reset goes to the read.
- **IDLE → accept.** Accepting pulses `ar_ready` (read), or `aw_ready` and `w_ready` together (write), combinationally in the same cycle. Address, data, strobe and prot are latched.
- **Decode.** On a decode miss, go to RESP with DECERR (2'b11) and issue no APB access.
- **Beat selection.** For writes, beats whose `pstrb` slice is 0 are skipped. If all slices are 0, go to RESP with OKAY and issue no APB access.
- **SETUP → ACCESS.** SETUP: `psel`=1 and `penable`=0, lasting 1 cycle. ACCESS: `penable`=1, held until `pready`.
- **ACCESS exit.** On `pready`, capture `prdata` into read byte lane k and OR `pslverr` into a sticky error flag. Then go to SETUP for the next active beat, or to RESP after the last one. An error does not abort the remaining beats.
- **RESP.** Assert `b_valid` or `r_valid` with resp = SLVERR (2'b10) if the sticky flag is set, otherwise OKAY. Unread R lanes are 0. Hold until `b_ready`/`r_ready`, then return to IDLE.
- `pprot` equals the latched AXI prot. `psel`/`penable` are 0 outside SETUP/ACCESS.

## Timing
- Reset values: all `psel`/`penable` = 0; `aw_ready`/`w_ready`/`ar_ready` = 0; `b_valid`/`r_valid` = 0; `paddr`/`pwdata`/`pstrb`/`r_data` = 0; FSM = IDLE; the arbitration pointer favours read.
- Single-beat latency with zero-wait `pready`: accept in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, valid in cycle 3.
- Each extra beat adds 2 cycles plus that beat's wait cycles.
- A decode miss gives valid in cycle 1.
- Only one transaction is outstanding. Channel readies are 0 in every state other than IDLE.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are stable from SETUP through the end of ACCESS.
- Reset asserted mid-transaction clears everything immediately. The in-flight transaction is dropped with no response.

## Configuration
- `AXI_LITE_TO_APB_DW_TIMEOUT_EN` defined:
  - A per-beat counter runs in ACCESS.
  - After `TimeoutCycles` cycles without `pready`: deassert `psel`/`penable` in the following cycle, drop the remaining beats, and respond SLVERR.
  - A `pready` arriving in the same cycle as expiry wins, and the beat completes normally.
- Macro undefined: no counter is built, `TimeoutCycles` is ignored, and ACCESS waits for `pready` indefinitely.

## Test plan
- Read at 0x0000_3004 with AxiDataWidth=32, ApbDataWidth=8, slave 1 returning 0x11/0x22/0x33/0x44 with `pready`=1 → `psel[1]` is set for 4 beats at paddr 0x3004..0x3007; `r_data`=0x44332211, OKAY; `r_valid` asserts 9 cycles after accept.
- Write 0xA5A5_0000 with strb 4'b1100 to 0x0000_8000 → only beats 2 and 3 are issued (paddr 0x8002, 0x8003; pwdata 0xA5); then B OKAY. A write with strb 0 → no `psel`, B OKAY.
- Read at 0x0003_0000 (unmapped) → no `psel` toggles; R resp 2'b11 in cycle 1.
- Slave returns `pslverr`=1 on beat 1 of 4 → all 4 beats are still issued; resp 2'b10.
- AR and AW+W valid simultaneously for 4 consecutive requests → service order is R, W, R, W.
- Macro on with TimeoutCycles=16 and `pready` held 0 → `penable` drops after 16 ACCESS cycles; resp SLVERR; the next transaction proceeds normally.
